pmem_loader: RTL and testbench

PMEM_LOADER -- requirements
Module: pmem_loader

---
 rtl/pmem_loader.sv | 117 +++++++++++
 tb/tb_pmem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_loader.sv
// Program-memory loader: receives a counted, checksummed byte stream and writes
// 12-bit instructions into program memory while holding the CPU in reset.
module pmem_loader #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [7:0]  DIn,
    input  logic        DValid,
    output logic        DReady,
    output logic        LE,
    output logic [7:0]  LA,
    output logic [11:0] LI,
    output logic        E,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  ErrCode
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LO, S_HI, S_WR, S_SUM, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [8:0]    remaining;
    logic [7:0]    cksum;
    logic [7:0]    sum_next;
    logic [TW-1:0] tcnt;
    logic          accept;
    logic          timed_out;

    // Handshake and status outputs are pure decodes of the state register.
    assign DReady    = (state == S_COUNT) || (state == S_LO) ||
                       (state == S_HI)    || (state == S_SUM);
    assign Busy      = DReady || (state == S_WR);
    assign LE        = (state == S_WR);
    assign CpuHold   = Busy || (state == S_ERR);
    assign E         = !CpuHold;
    assign accept    = DValid && DReady;
    assign sum_next  = cksum + DIn;
    assign timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and
        // every state register (including LI) gets a defined value.
        if (!rst_n) begin
            state     <= S_IDLE;
            LA        <= '0;
            LI        <= '0;
            remaining <= '0;
            cksum     <= '0;
            tcnt      <= '0;
            Done      <= 1'b0;
            ErrCode   <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        state   <= S_COUNT;
                        Done    <= 1'b0;
                        ErrCode <= 2'b00;
                        LA      <= '0;
                        cksum   <= '0;
                        tcnt    <= '0;
                    end
                end
                S_COUNT, S_LO, S_HI, S_SUM: begin
                    // Timeout wins over a byte arriving on the same cycle.
                    if (timed_out) begin
                        state   <= S_ERR;
                        ErrCode <= 2'b01;
                    end else if (accept) begin
                        tcnt <= '0;
                        if (state != S_SUM)
                            cksum <= sum_next;
                        case (state)
                            S_COUNT: begin
                                remaining <= (DIn == 8'd0) ? 9'd256 : {1'b0, DIn};
                                state     <= S_LO;
                            end
                            S_LO: begin
                                LI[7:0] <= DIn;
                                state   <= S_HI;
                            end
                            S_HI: begin
                                LI[11:8] <= DIn[3:0];
                                state    <= S_WR;
                            end
                            default: begin
                                if (sum_next == 8'd0) begin
                                    state <= S_DONE;
                                    Done  <= 1'b1;
                                end else begin
                                    state   <= S_ERR;
                                    ErrCode <= 2'b10;
                                end
                            end
                        endcase
                    end else if (TIMEOUT != 0) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WR: begin
                    LA        <= LA + 8'd1;
                    remaining <= remaining - 9'd1;
                    state     <= (remaining == 9'd1) ? S_SUM : S_LO;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: expected memory writes are queued as bytes are
// driven and matched against each LE pulse.
module tb_pmem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  DIn = 8'h00;
    logic        DValid = 1'b0;
    logic        DReady, LE, E, CpuHold, Busy, Done;
    logic [7:0]  LA;
    logic [11:0] LI;
    logic [1:0]  ErrCode;

    typedef struct packed {
        logic [7:0]  la;
        logic [11:0] li;
    } wr_t;

    wr_t  exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_le = 0;
    int   le_gap = 0;
    int   le_count = 0;
    logic [7:0] cks;

    pmem_loader #(.TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .DIn(DIn), .DValid(DValid),
        .DReady(DReady), .LE(LE), .LA(LA), .LI(LI), .E(E), .CpuHold(CpuHold),
        .Busy(Busy), .Done(Done), .ErrCode(ErrCode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Every LE pulse must match the oldest queued write.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (LE === 1'b1) begin
            le_count++;
            le_gap  = cyc - last_le;
            last_le = cyc;
            check("dready_in_wr", 32'(DReady), 32'd0);
            if (exp_q.size() == 0) begin
                check("le_unexpected", 32'(LE), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("la", 32'(LA), 32'(w.la));
                check("li", 32'(LI), 32'(w.li));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b, input bit rnd);
        int n = 0;
        if (rnd) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin
                DValid = 1'b0;
                @(negedge clk);
            end
        end
        DIn    = b;
        DValid = 1'b1;
        while (!DReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!DReady) check("accept_timeout", 32'd0, 32'd1);
        else @(negedge clk);
    endtask

    task automatic send_pair(input logic [7:0] la, input logic [7:0] lo,
                             input logic [7:0] hi, input bit rnd);
        exp_q.push_back('{la: la, li: {hi[3:0], lo}});
        cks = cks + lo + hi;
        send(lo, rnd);
        send(hi, rnd);
    endtask

    task automatic start_load();
        Start  = 1'b1;
        DValid = 1'b0;
        @(negedge clk);
        Start  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        DValid = 1'b0;
        while (Busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_le"},      32'(LE),      32'd0);
        check({tag, "_la"},      32'(LA),      32'd0);
        check({tag, "_li"},      32'(LI),      32'd0);
        check({tag, "_dready"},  32'(DReady),  32'd0);
        check({tag, "_busy"},    32'(Busy),    32'd0);
        check({tag, "_done"},    32'(Done),    32'd0);
        check({tag, "_err"},     32'(ErrCode), 32'd0);
        check({tag, "_cpuhold"}, 32'(CpuHold), 32'd0);
        check({tag, "_e"},       32'(E),       32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Known-good two-instruction load, DValid held high.
        base = le_count;
        start_load();
        cks = 8'h02;
        send(8'h02, 1'b0);
        send_pair(8'h00, 8'h34, 8'h01, 1'b0);
        send_pair(8'h01, 8'h78, 8'h0A, 1'b0);
        send(8'h47, 1'b0);
        wait_idle();
        check("t1_done",   32'(Done),    32'd1);
        check("t1_err",    32'(ErrCode), 32'd0);
        check("t1_e",      32'(E),       32'd1);
        check("t1_hold",   32'(CpuHold), 32'd0);
        check("t1_lecnt",  32'(le_count - base), 32'd2);
        check("t1_gap",    32'(le_gap),  32'd3);
        check("t1_qempty", 32'(exp_q.size()), 32'd0);

        // Same stream with a bad checksum.
        base = le_count;
        start_load();
        send(8'h02, 1'b0);
        send_pair(8'h00, 8'h34, 8'h01, 1'b0);
        send_pair(8'h01, 8'h78, 8'h0A, 1'b0);
        send(8'h48, 1'b0);
        wait_idle();
        check("t2_err",   32'(ErrCode), 32'd2);
        check("t2_done",  32'(Done),    32'd0);
        check("t2_hold",  32'(CpuHold), 32'd1);
        check("t2_e",     32'(E),       32'd0);
        check("t2_lecnt", 32'(le_count - base), 32'd2);

        // Timeout after the count byte with TIMEOUT=10.
        base = le_count;
        start_load();
        send(8'h01, 1'b0);
        DValid = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_not_early", 32'(Busy), 32'd1);
        @(negedge clk);
        check("t3_busy",  32'(Busy),    32'd0);
        check("t3_err",   32'(ErrCode), 32'd1);
        check("t3_lecnt", 32'(le_count - base), 32'd0);

        // Count byte 00 means 256 instructions.
        base = le_count;
        start_load();
        cks = 8'h00;
        send(8'h00, 1'b0);
        for (int i = 0; i < 256; i++)
            send_pair(8'(i), 8'($urandom), 8'($urandom), 1'b0);
        send(8'(8'h00 - cks), 1'b0);
        wait_idle();
        check("t4_done",  32'(Done),    32'd1);
        check("t4_err",   32'(ErrCode), 32'd0);
        check("t4_la",    32'(LA),      32'd0);
        check("t4_lecnt", 32'(le_count - base), 32'd256);
        check("t4_gap",   32'(le_gap),  32'd3);

        // Randomly gapped DValid over a three-instruction load.
        base = le_count;
        start_load();
        cks = 8'h03;
        send(8'h03, 1'b1);
        for (int i = 0; i < 3; i++)
            send_pair(8'(i), 8'($urandom), 8'($urandom), 1'b1);
        send(8'(8'h00 - cks), 1'b1);
        wait_idle();
        check("t5_done",  32'(Done),    32'd1);
        check("t5_lecnt", 32'(le_count - base), 32'd3);
        check("t5_qempty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for the HI byte.
        base = le_count;
        start_load();
        send(8'h01, 1'b0);
        send(8'h55, 1'b0);
        DValid = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check_reset_values("t6_rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_lecnt", 32'(le_count - base), 32'd0);
        check("t6_idle_e", 32'(E), 32'd1);

        // Start pulsed mid-load must be ignored.
        base = le_count;
        start_load();
        cks = 8'h02;
        send(8'h02, 1'b0);
        send_pair(8'h00, 8'hC3, 8'hF5, 1'b0);
        start_load();
        check("t7_busy", 32'(Busy), 32'd1);
        send_pair(8'h01, 8'h0F, 8'h3C, 1'b0);
        send(8'(8'h00 - cks), 1'b0);
        wait_idle();
        check("t7_done",  32'(Done),    32'd1);
        check("t7_la",    32'(LA),      32'd2);
        check("t7_lecnt", 32'(le_count - base), 32'd2);
        check("t7_qempty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
